// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared defaults and pointer-width helper for the handshake FIFO path
package handshake_pkg;

  localparam int DEFAULT_WIDTH = 9;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AFULL = 12;

  // Ceiling log2, usable in constant (parameter) contexts.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_2d.sv
// rtl/fifo_mem_2d.sv - DEPTH x WIDTH register array, sync write port, async read port
module fifo_mem_2d
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]        wr_data_i,
  input  logic [clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]        rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Combinational read so the head word falls through to the output.
  always_comb begin
    rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/handshake_fifo.sv
// rtl/handshake_fifo.sv - first-word-fall-through elastic buffer between source and destination
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AFULL = DEFAULT_AFULL
) (
  input  logic                  clk,
  input  logic                  s_rst_n,
  input  logic                  in_vaild,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_vaild,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [clog2(DEPTH):0] count,
  output logic                  almost_full
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  // Flags come only from registered pointers: no path from out_ready to in_ready.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push  = in_vaild && !full;
    pop   = out_ready && !empty;
  end

  // Next-state for pointers (wrap modulo 2*DEPTH through natural overflow) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Control state; reset discards all contents immediately.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem_2d #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (in_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (out_data)
  );

  // Status outputs, all derived from registered state.
  always_comb begin
    in_ready    = !full;
    out_vaild   = !empty;
    count       = count_q;
    almost_full = (count_q >= AFULL_C);
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// tb/tb_handshake_fifo.sv - directed self-checking bench for handshake_fifo
module tb_handshake_fifo;

  logic       clk = 1'b0;
  logic       s_rst_n;
  logic       in_vaild;
  logic [8:0] in_data;
  logic       in_ready;
  logic       out_vaild;
  logic [8:0] out_data;
  logic       out_ready;
  logic [4:0] count;
  logic       almost_full;

  int n_checks = 0;
  int n_fail   = 0;
  int mc;

  handshake_fifo #(.WIDTH(9), .DEPTH(16), .AFULL(12)) dut (
    .clk         (clk),
    .s_rst_n     (s_rst_n),
    .in_vaild    (in_vaild),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_vaild   (out_vaild),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_ovalid"}, out_vaild, 1'b0);
    chk1({tag, "_iready"}, in_ready, 1'b1);
    chk5({tag, "_count"}, count, 5'd0);
    chk1({tag, "_afull"}, almost_full, 1'b0);
  endtask

  initial begin
    // 1. reset then idle
    s_rst_n = 1'b0; in_vaild = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("rst");
    end
    s_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle");
    end

    // 2. fill to full with destination stalled
    for (int i = 0; i < 16; i++) begin
      in_vaild = 1'b1; in_data = 9'(i);
      chk1("fill_iready", in_ready, 1'b1);
      tick();
      chk5("fill_count", count, 5'(i + 1));
      chk1("fill_afull", almost_full, (i + 1) >= 12);
      chk9("fill_head", out_data, 9'h000);
    end
    chk1("full_iready", in_ready, 1'b0);
    in_data = 9'h1FF;
    tick(); tick();
    chk5("full_hold_count", count, 5'd16);
    chk1("full_hold_iready", in_ready, 1'b0);
    chk9("full_hold_head", out_data, 9'h000);
    in_vaild = 1'b0;

    // 3. drain in order; a pop at full frees space next cycle
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk1("drain_ovalid", out_vaild, 1'b1);
      chk9("drain_data", out_data, 9'(i));
      tick();
      if (i == 0) chk1("drain_iready_after_full", in_ready, 1'b1);
    end
    chk1("drain_empty", out_vaild, 1'b0);
    chk5("drain_count", count, 5'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vaild = 1'b1; in_data = 9'h100 + 9'(i);
      tick();
    end
    in_vaild = 1'b0;
    chk5("wrap_count", count, 5'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk9("wrap_data", out_data, 9'h100 + 9'(i));
      tick();
    end
    chk1("wrap_empty", out_vaild, 1'b0);
    out_ready = 1'b0;

    // 4. simultaneous push/pop at count 5 (pointers wrap past 2*DEPTH here)
    for (int i = 0; i < 5; i++) begin
      in_vaild = 1'b1; in_data = 9'h020 + 9'(i);
      tick();
    end
    chk5("pp_start_count", count, 5'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 9'h030 + 9'(i);
      chk9("pp_data", out_data, (i < 5) ? 9'h020 + 9'(i) : 9'h030 + 9'(i - 5));
      tick();
      chk5("pp_count", count, 5'd5);
    end
    in_vaild = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk9("pp_tail", out_data, 9'h030 + 9'(15 + i));
      tick();
    end
    chk5("pp_end_count", count, 5'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_vaild = 1'b1; in_data = 9'h040 + 9'(i);
      tick();
    end
    in_data = 9'h1AA; out_ready = 1'b1;
    chk1("fullpp_iready", in_ready, 1'b0);
    tick();
    chk5("fullpp_count", count, 5'd15);
    chk1("fullpp_iready_next", in_ready, 1'b1);
    chk9("fullpp_head", out_data, 9'h041);
    tick();
    chk5("fullpp_count2", count, 5'd15);
    in_vaild = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk9("fullpp_drain", out_data, (i < 14) ? 9'h042 + 9'(i) : 9'h1AA);
      tick();
    end
    chk1("fullpp_empty", out_vaild, 1'b0);
    chk5("fullpp_end_count", count, 5'd0);

    // 5. empty first-word timing, no bypass
    in_vaild = 1'b1; in_data = 9'h0A5; out_ready = 1'b1;
    chk1("ffw_no_bypass", out_vaild, 1'b0);
    tick();
    in_vaild = 1'b0;
    chk1("ffw_ovalid", out_vaild, 1'b1);
    chk9("ffw_data", out_data, 9'h0A5);
    chk5("ffw_count", count, 5'd1);
    tick();
    chk1("ffw_popped", out_vaild, 1'b0);
    chk5("ffw_count0", count, 5'd0);

    // 6. reset mid-operation with random backpressure
    mc = 0;
    in_vaild = 1'b1;
    for (int i = 0; i < 500 && mc != 9; i++) begin
      in_data = 9'(i);
      out_ready = ($urandom_range(0, 3) == 0);
      tick();
      if (!(out_ready && mc > 0)) mc++;
    end
    chk5("mid_count9", count, 5'd9);
    out_ready = 1'b0;
    #3 s_rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    in_data = 9'h1EE;
    tick();
    chk_idle("rst_offer");
    s_rst_n = 1'b1;
    in_data = 9'h055;
    tick();
    in_vaild = 1'b0;
    chk1("post_rst_ovalid", out_vaild, 1'b1);
    chk9("post_rst_data", out_data, 9'h055);
    chk5("post_rst_count", count, 5'd1);
    out_ready = 1'b1;
    tick();
    chk1("post_rst_empty", out_vaild, 1'b0);
    chk5("post_rst_count0", count, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
